ps2_packet_receiver: RTL and testbench
======================================

PS2_PACKET_RECEIVER -- requirements
Module: ps2_packet_receiver

Interface
REQ-001 Parameter FILTER_LEN, default 4: consecutive equal synchronised samples needed before the filtered PS2CLK changes.
REQ-002 Parameter PKT_BYTES, default 3, legal 1..4: bytes per assembled packet.
REQ-003 Parameter TIMEOUT_CYC, default 5000: CLK cycles without a PS2CLK falling edge before an in-progress frame/packet is aborted.
REQ-004 Parameter CHECK_SYNC, default 1: 1 = byte 0 of a packet must have bit 3 set (mouse sync bit).
REQ-005 CLK  input  1  sole clock; all state updates on rising edge.
REQ-006 RST  input  1  asynchronous, active-low reset.
REQ-007 PS2CLK  input  1  PS/2 clock line, asynchronous to CLK.
REQ-008 PS2DATA  input  1  PS/2 data line, asynchronous to CLK.
REQ-009 tx_idle  input  1  1 = host transmitter idle, reception enabled.
REQ-010 dataout  output  8  last valid received byte.
REQ-011 rx_done  output  1  one-cycle pulse per valid byte.
REQ-012 packet  output  8*PKT_BYTES  last complete packet, byte k in bits [8k+7:8k].
REQ-013 pkt_valid  output  1  one-cycle pulse per complete packet.
REQ-014 STREAM  output  1  high while a frame or packet is in progress.
REQ-015 FAIL  output  1  one-cycle pulse on any frame error.
REQ-016 err_code  output  2  cause of last FAIL: 01 parity, 10 stop, 11 timeout; held until next FAIL.

Function
REQ-017 PS2CLK and PS2DATA SHALL each pass a 2-flop synchroniser; the filtered clock (reset value 1) SHALL change only after FILTER_LEN consecutive equal synchronised samples.
REQ-018 A filtered-clock 1->0 transition SHALL generate a one-cycle sample strobe; the synchronised PS2DATA is sampled on that strobe.
REQ-019 Frame FSM states: IDLE, DATA, PARITY, STOP.
REQ-020 IDLE: strobe with data 0 and tx_idle=1 -> DATA, bit counter 0; strobe with data 1 SHALL be ignored.
REQ-021 DATA: 8 strobes shift bits in LSB first, then -> PARITY.
REQ-022 PARITY: sampled bit SHALL make the 9-bit data+parity count odd; mismatch recorded, -> STOP.
REQ-023 STOP: on strobe -> IDLE; stop=1 and parity good -> valid byte; parity bad -> FAIL, err_code 01; stop=0 with parity good -> FAIL, err_code 10.
REQ-024 Valid byte: dataout updated and rx_done pulsed in the cycle after the stop-bit strobe.
REQ-025 Any FAIL SHALL discard the byte and reset packet index to 0; packet output unchanged.
REQ-026 Timeout counter clears on every strobe and while STREAM=0; reaching TIMEOUT_CYC-1 SHALL force IDLE, index 0, FAIL with err_code 11.
REQ-027 tx_idle=0 SHALL force IDLE and index 0 within one cycle, without FAIL; filter and synchronisers keep running.
REQ-028 Packet assembly: valid byte written to slot index, index increments; with CHECK_SYNC=1 a byte at index 0 with bit 3 = 0 SHALL be dropped (rx_done still pulses, no FAIL, index stays 0).
REQ-029 On the PKT_BYTES-th valid byte, packet SHALL update with all bytes and pkt_valid SHALL pulse in the same cycle as that rx_done; index wraps to 0.
REQ-030 Partial packet bytes SHALL NOT appear on packet until the packet completes.
REQ-031 STREAM = (FSM != IDLE) or (index != 0), registered.

Reset
REQ-032 RST low SHALL asynchronously clear dataout, packet, rx_done, pkt_valid, FAIL, err_code, STREAM, index, counters to 0, FSM to IDLE, filtered/synchronised lines to 1.
REQ-033 Reset asserted mid-frame SHALL produce no rx_done, pkt_valid or FAIL on release.

Verification
REQ-034 Frames 0x08, 0x05, 0xFB (odd parity, stop 1), PKT_BYTES=3 -> three rx_done, pkt_valid once with packet=0xFB0508, STREAM low afterwards.
REQ-035 Frame 0x08 with parity bit inverted -> FAIL pulse, err_code=01, no rx_done, index 0.
REQ-036 Frame 0x08 with stop bit 0 -> FAIL, err_code=10; next good 3-byte packet assembles normally.
REQ-037 Two bytes of a packet then PS2CLK held high TIMEOUT_CYC cycles -> FAIL, err_code=11, STREAM=0, packet unchanged.
REQ-038 First byte 0x00 with CHECK_SYNC=1 -> rx_done, dataout=0x00, no FAIL, index stays 0; following 0x09,0x01,0x02 -> packet=0x020109.
REQ-039 PS2CLK glitch low shorter than FILTER_LEN cycles in IDLE and mid-DATA -> no strobe, received byte unaffected.

Source files
------------

// File: rtl/ps2_packet_receiver.sv
// PS/2 receiver: synchronises and glitch-filters the PS/2 lines, decodes 11-bit frames
// and assembles validated bytes into fixed-length packets (mouse style).
module ps2_packet_receiver #(
  parameter int FILTER_LEN  = 4,
  parameter int PKT_BYTES   = 3,
  parameter int TIMEOUT_CYC = 5000,
  parameter int CHECK_SYNC  = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   PS2CLK,
  input  logic                   PS2DATA,
  input  logic                   tx_idle,
  output logic [7:0]             dataout,
  output logic                   rx_done,
  output logic [8*PKT_BYTES-1:0] packet,
  output logic                   pkt_valid,
  output logic                   STREAM,
  output logic                   FAIL,
  output logic [1:0]             err_code
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int IW = $clog2(PKT_BYTES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                   state_q, state_d;
  logic [1:0]               clk_sync_q, dat_sync_q;
  logic                     filt_clk_q, filt_clk_d;
  logic [FW-1:0]            filt_cnt_q, filt_cnt_d;
  logic                     strobe_q, strobe_d;
  logic [2:0]               bit_cnt_q, bit_cnt_d;
  logic [7:0]               shift_q, shift_d;
  logic                     par_bad_q, par_bad_d;
  logic [TW-1:0]            to_cnt_q, to_cnt_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [7:0]               slots_q [PKT_BYTES], slots_d [PKT_BYTES];
  logic [7:0]               dataout_q, dataout_d;
  logic [8*PKT_BYTES-1:0]   packet_q, packet_d;
  logic                     rx_done_q, rx_done_d;
  logic                     pkt_valid_q, pkt_valid_d;
  logic                     stream_q, stream_d;
  logic                     fail_q, fail_d;
  logic [1:0]               err_q, err_d;
  logic                     dat;
  logic                     timeout;

  assign dat     = dat_sync_q[1];
  assign timeout = stream_q && (to_cnt_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!tx_idle || timeout) begin
      state_d = S_IDLE;
    end else if (strobe_q) begin
      case (state_q)
        S_IDLE:   if (!dat) state_d = S_DATA;
        S_DATA:   if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        S_PARITY: state_d = S_STOP;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    // The filtered clock only moves after FILTER_LEN consecutive disagreeing samples.
    filt_clk_d = filt_clk_q;
    filt_cnt_d = '0;
    if (clk_sync_q[1] != filt_clk_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) filt_clk_d = clk_sync_q[1];
      else                                   filt_cnt_d = filt_cnt_q + 1'b1;
    end
    strobe_d = filt_clk_q & ~filt_clk_d;

    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_bad_d   = par_bad_q;
    idx_d       = idx_q;
    slots_d     = slots_q;
    dataout_d   = dataout_q;
    packet_d    = packet_q;
    rx_done_d   = 1'b0;
    pkt_valid_d = 1'b0;
    fail_d      = 1'b0;
    err_d       = err_q;
    to_cnt_d    = (strobe_q || !stream_q) ? '0 : to_cnt_q + 1'b1;

    if (!tx_idle) begin
      idx_d = '0;
    end else if (timeout) begin
      idx_d    = '0;
      fail_d   = 1'b1;
      err_d    = 2'b11;
      to_cnt_d = '0;
    end else if (strobe_q) begin
      case (state_q)
        S_IDLE: begin
          bit_cnt_d = '0;
        end
        S_DATA: begin
          shift_d   = {dat, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
        S_PARITY: begin
          par_bad_d = ~(^{dat, shift_q});
        end
        default: begin
          if (par_bad_q) begin
            fail_d = 1'b1;
            err_d  = 2'b01;
            idx_d  = '0;
          end else if (!dat) begin
            fail_d = 1'b1;
            err_d  = 2'b10;
            idx_d  = '0;
          end else begin
            dataout_d = shift_q;
            rx_done_d = 1'b1;
            // A leading byte without the sync bit is reported but not stored.
            if (CHECK_SYNC != 0 && idx_q == '0 && !shift_q[3]) begin
              idx_d = '0;
            end else if (idx_q == IW'(PKT_BYTES - 1)) begin
              for (int k = 0; k < PKT_BYTES - 1; k++) packet_d[8*k +: 8] = slots_q[k];
              packet_d[8*(PKT_BYTES-1) +: 8] = shift_q;
              pkt_valid_d = 1'b1;
              idx_d       = '0;
            end else begin
              slots_d[idx_q] = shift_q;
              idx_d          = idx_q + 1'b1;
            end
          end
        end
      endcase
    end

    stream_d = (state_d != S_IDLE) || (idx_d != '0);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      clk_sync_q  <= 2'b11;
      dat_sync_q  <= 2'b11;
      filt_clk_q  <= 1'b1;
      filt_cnt_q  <= '0;
      strobe_q    <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_bad_q   <= 1'b0;
      to_cnt_q    <= '0;
      idx_q       <= '0;
      for (int k = 0; k < PKT_BYTES; k++) slots_q[k] <= '0;
      dataout_q   <= '0;
      packet_q    <= '0;
      rx_done_q   <= 1'b0;
      pkt_valid_q <= 1'b0;
      stream_q    <= 1'b0;
      fail_q      <= 1'b0;
      err_q       <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], PS2CLK};
      dat_sync_q  <= {dat_sync_q[0], PS2DATA};
      filt_clk_q  <= filt_clk_d;
      filt_cnt_q  <= filt_cnt_d;
      strobe_q    <= strobe_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_bad_q   <= par_bad_d;
      to_cnt_q    <= to_cnt_d;
      idx_q       <= idx_d;
      slots_q     <= slots_d;
      dataout_q   <= dataout_d;
      packet_q    <= packet_d;
      rx_done_q   <= rx_done_d;
      pkt_valid_q <= pkt_valid_d;
      stream_q    <= stream_d;
      fail_q      <= fail_d;
      err_q       <= err_d;
    end
  end

  assign dataout   = dataout_q;
  assign packet    = packet_q;
  assign rx_done   = rx_done_q;
  assign pkt_valid = pkt_valid_q;
  assign STREAM    = stream_q;
  assign FAIL      = fail_q;
  assign err_code  = err_q;

endmodule

// File: tb/tb_ps2_packet_receiver.sv
// Bench for ps2_packet_receiver: directed scenarios plus random frames, checked
// against a frame-level model of packet assembly and error reporting.
module tb_ps2_packet_receiver;

  localparam int FL   = 4;
  localparam int P    = 3;
  localparam int TO   = 5000;
  localparam int CS   = 1;
  localparam int HALF = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ps2clk = 1'b1;
  logic          ps2dat = 1'b1;
  logic          tx_idle = 1'b1;
  logic [7:0]    dataout;
  logic          rx_done;
  logic [8*P-1:0] packet;
  logic          pkt_valid;
  logic          stream;
  logic          fail;
  logic [1:0]    err_code;

  ps2_packet_receiver #(.FILTER_LEN(FL), .PKT_BYTES(P), .TIMEOUT_CYC(TO), .CHECK_SYNC(CS)) dut (
    .CLK(clk), .RST(rst_n), .PS2CLK(ps2clk), .PS2DATA(ps2dat), .tx_idle(tx_idle),
    .dataout(dataout), .rx_done(rx_done), .packet(packet), .pkt_valid(pkt_valid),
    .STREAM(stream), .FAIL(fail), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Pulse monitor
  int mon_rx = 0, mon_pv = 0, mon_fail = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_done) mon_rx++;
      if (fail) mon_fail++;
      if (pkt_valid) begin
        mon_pv++;
        check("pkt_valid_with_rx_done", 32'(rx_done), 32'd1);
      end
    end
  end

  // Frame-level reference model
  int          exp_rx = 0, exp_pv = 0, exp_fail = 0, exp_idx = 0;
  logic [7:0]  exp_dout = 8'h00;
  logic [8*P-1:0] exp_packet = '0;
  logic [1:0]  exp_err = 2'b00;
  logic [7:0]  part [P];

  task automatic model_frame(input logic [7:0] b, input bit par_flip, input bit stop_bit);
    if (par_flip) begin
      exp_fail++; exp_err = 2'b01; exp_idx = 0;
    end else if (!stop_bit) begin
      exp_fail++; exp_err = 2'b10; exp_idx = 0;
    end else begin
      exp_rx++;
      exp_dout = b;
      if (!(CS != 0 && exp_idx == 0 && b[3] == 1'b0)) begin
        part[exp_idx] = b;
        exp_idx++;
        if (exp_idx == P) begin
          for (int k = 0; k < P; k++) exp_packet[8*k +: 8] = part[k];
          exp_pv++;
          exp_idx = 0;
        end
      end
    end
  endtask

  task automatic check_all(input string label);
    check("rx_done_count", 32'(mon_rx), 32'(exp_rx));
    check("pkt_valid_count", 32'(mon_pv), 32'(exp_pv));
    check("fail_count", 32'(mon_fail), 32'(exp_fail));
    check("dataout", 32'(dataout), 32'(exp_dout));
    check("packet", 32'(packet), 32'(exp_packet));
    check("err_code", 32'(err_code), 32'(exp_err));
    check("stream", 32'(stream), 32'(exp_idx != 0));
    $display("%s: dataout=%02h packet=%06h err=%0d stream=%0d rx=%0d pv=%0d errs=%0d",
             label, dataout, packet, err_code, stream, mon_rx, mon_pv, mon_fail);
  endtask

  // Drives one frame; optional glitch in a bit's high phase, tx_idle drop, or early abort.
  task automatic send_frame(input logic [7:0] b, input bit par_flip, input bit stop_bit,
                            input int glitch_bit, input int idle_drop_bit, input int stop_after);
    logic [10:0] bits;
    bits = {stop_bit, (~^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      if (i == stop_after) break;
      if (i == idle_drop_bit) tx_idle = 1'b0;
      ps2dat = bits[i];
      repeat (HALF) @(negedge clk);
      if (i == glitch_bit) begin
        ps2clk = 1'b0;
        repeat (2) @(negedge clk);
        ps2clk = 1'b1;
        repeat (HALF) @(negedge clk);
      end
      ps2clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2clk = 1'b1;
    end
    ps2dat = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic run_frame(input logic [7:0] b, input bit par_flip, input bit stop_bit, input int glitch_bit);
    string label;
    send_frame(b, par_flip, stop_bit, glitch_bit, -1, -1);
    model_frame(b, par_flip, stop_bit);
    repeat (10) @(negedge clk);
    label = $sformatf("frame %02h pflip=%0d stop=%0d", b, par_flip, stop_bit);
    check_all(label);
  endtask

  initial begin
    for (int k = 0; k < P; k++) part[k] = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_dataout", 32'(dataout), 32'd0);
    check("reset_packet", 32'(packet), 32'd0);
    check("reset_rx_done", 32'(rx_done), 32'd0);
    check("reset_pkt_valid", 32'(pkt_valid), 32'd0);
    check("reset_fail", 32'(fail), 32'd0);
    check("reset_err_code", 32'(err_code), 32'd0);
    check("reset_stream", 32'(stream), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Basic three-byte packet
    run_frame(8'h08, 1'b0, 1'b1, -1);
    run_frame(8'h05, 1'b0, 1'b1, -1);
    run_frame(8'hFB, 1'b0, 1'b1, -1);
    check("basic_packet", 32'(packet), 32'hFB0508);

    // Parity error, then stop-bit error followed by a good packet
    run_frame(8'h08, 1'b1, 1'b1, -1);
    check("parity_err_code", 32'(err_code), 32'd1);
    run_frame(8'h08, 1'b0, 1'b0, -1);
    check("stop_err_code", 32'(err_code), 32'd2);
    run_frame(8'h18, 1'b0, 1'b1, -1);
    run_frame(8'h22, 1'b0, 1'b1, -1);
    run_frame(8'h33, 1'b0, 1'b1, -1);
    check("after_stop_err_packet", 32'(packet), 32'h332218);

    // Sync-bit drop
    run_frame(8'h00, 1'b0, 1'b1, -1);
    check("sync_drop_dataout", 32'(dataout), 32'h00);
    run_frame(8'h09, 1'b0, 1'b1, -1);
    run_frame(8'h01, 1'b0, 1'b1, -1);
    run_frame(8'h02, 1'b0, 1'b1, -1);
    check("sync_packet", 32'(packet), 32'h020109);

    // Timeout after two bytes of a packet
    run_frame(8'h0C, 1'b0, 1'b1, -1);
    run_frame(8'h44, 1'b0, 1'b1, -1);
    repeat (TO + 40) @(negedge clk);
    exp_fail++; exp_err = 2'b11; exp_idx = 0;
    check_all("timeout");

    // Glitches: idle with data low, then mid-data
    ps2dat = 1'b0;
    repeat (5) @(negedge clk);
    ps2clk = 1'b0;
    repeat (2) @(negedge clk);
    ps2clk = 1'b1;
    repeat (5) @(negedge clk);
    ps2dat = 1'b1;
    repeat (20) @(negedge clk);
    run_frame(8'h28, 1'b0, 1'b1, -1);
    run_frame(8'hA5, 1'b0, 1'b1, 4);
    run_frame(8'h3C, 1'b0, 1'b1, 7);
    check("glitch_packet", 32'(packet), 32'h3CA528);

    // tx_idle drop mid-frame discards the partial packet without an error
    run_frame(8'h08, 1'b0, 1'b1, -1);
    send_frame(8'h77, 1'b0, 1'b1, -1, 4, -1);
    repeat (10) @(negedge clk);
    exp_idx = 0;
    check_all("tx_idle_drop");
    tx_idle = 1'b1;
    repeat (5) @(negedge clk);
    run_frame(8'h19, 1'b0, 1'b1, -1);
    run_frame(8'h2A, 1'b0, 1'b1, -1);
    run_frame(8'h3B, 1'b0, 1'b1, -1);

    // Random frames
    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      int r;
      b = 8'($urandom);
      r = int'($urandom_range(0, 9));
      run_frame(b, r == 0, r != 1, -1);
      repeat ($urandom_range(5, 300)) @(negedge clk);
    end

    // Reset asserted mid-frame
    send_frame(8'h5A, 1'b0, 1'b1, -1, -1, 5);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    exp_dout = 8'h00; exp_packet = '0; exp_err = 2'b00; exp_idx = 0;
    check_all("mid_frame_reset");
    run_frame(8'h09, 1'b0, 1'b1, -1);
    run_frame(8'h01, 1'b0, 1'b1, -1);
    run_frame(8'h02, 1'b0, 1'b1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
